// File: rtl/multiport_regfile.sv
// Register file with one write port and NUM_RD two-stage registered read ports, plus a write-lock
// mode, optional same-edge write forwarding, a one-word-per-cycle bulk clear and error pulses.

module multiport_regfile_rdport #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);
    logic [1:0]        vld_pipe_q;
    logic [DATA_W-1:0] s1_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            data_q     <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], rd_en_i};
            if (rd_en_i)       s1_q   <= word_i;
            // Output word only moves when a request completes, so idle ports hold their last result.
            if (vld_pipe_q[0]) data_q <= s1_q;
        end
    end

    assign rd_data_o  = data_q;
    assign rd_valid_o = vld_pipe_q[1];
endmodule

module multiport_regfile #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 32,
    parameter int                NUM_RD      = 3,
    parameter int                BYPASS      = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
    localparam int               ADDR_W      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     clear_done,
    output logic                     err_wr,
    output logic                     err_addr
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic                         err_wr_q, err_addr_q;
    logic                         wr_allowed, wr_fire;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_wa;
    logic [DATA_W-1:0]            mem_wd;
    logic [NUM_RD-1:0]            rd_oor;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(DEPTH);
    endfunction

    assign wr_allowed = !mode && (state_q == S_IDLE) && !clear_req;
    assign wr_fire    = write_enable && wr_allowed && in_range(wr_addr);

    // The clear sweep owns the memory write port while active.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = wr_fire;
        mem_wa  = wr_addr;
        mem_wd  = wr_data;
        case (state_q)
            S_IDLE: if (clear_req) begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = CLEAR_VALUE;
                if (cnt_q == ADDR_W'(DEPTH-1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              ok;
        logic [DATA_W-1:0] word;

        assign ra        = rd_addr[p*ADDR_W +: ADDR_W];
        assign ok        = in_range(ra);
        assign rd_oor[p] = rd_en[p] && !ok;

        always_comb begin
            word = '0;
            if (ok) begin
                word = mem_q[ra];
                if (BYPASS != 0 && mem_we && mem_wa == ra) word = mem_wd;
            end
        end

        multiport_regfile_rdport #(.DATA_W(DATA_W)) u_port (
            .clk       (clk),
            .rst_n     (reset),
            .rd_en_i   (rd_en[p]),
            .word_i    (word),
            .rd_data_o (rd_data[p*DATA_W +: DATA_W]),
            .rd_valid_o(rd_valid[p])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mem_q      <= '0;
            err_wr_q   <= 1'b0;
            err_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (mem_we) mem_q[mem_wa] <= mem_wd;
            err_wr_q   <= write_enable && !wr_allowed;
            err_addr_q <= (write_enable && !in_range(wr_addr)) || (|rd_oor);
        end
    end

    assign busy       = (state_q == S_CLEAR);
    assign clear_done = (state_q == S_DONE);
    assign err_wr     = err_wr_q;
    assign err_addr   = err_addr_q;
endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: instance A uses defaults (scoreboarded reads), instance B uses
// DEPTH=20, BYPASS=0 and a non-zero clear word for range, no-forward and clear-value cases.
module tb_multiport_regfile;
    localparam int DW = 32, D = 32, NR = 3, AW = 5, BD = 20;
    localparam logic [DW-1:0] BCV = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           we, mode, clr;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wd;
    logic [NR-1:0]  ren;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]  rvld;
    logic           busy, cdone, ewr, eaddr;

    logic           b_we, b_mode, b_clr, b_ren;
    logic [AW-1:0]  b_wa, b_raddr;
    logic [DW-1:0]  b_wd, b_rdata;
    logic           b_rvld, b_busy, b_done, b_ewr, b_eaddr;

    int checks = 0, errors = 0, cyc = 0;

    multiport_regfile dut (
        .clk(clk), .reset(reset), .write_enable(we), .mode(mode), .wr_addr(wa), .wr_data(wd),
        .rd_en(ren), .rd_addr(raddr), .rd_data(rdata), .rd_valid(rvld), .clear_req(clr),
        .busy(busy), .clear_done(cdone), .err_wr(ewr), .err_addr(eaddr)
    );

    multiport_regfile #(.DEPTH(BD), .NUM_RD(1), .BYPASS(0), .CLEAR_VALUE(BCV)) dut_b (
        .clk(clk), .reset(reset), .write_enable(b_we), .mode(b_mode), .wr_addr(b_wa), .wr_data(b_wd),
        .rd_en(b_ren), .rd_addr(b_raddr), .rd_data(b_rdata), .rd_valid(b_rvld), .clear_req(b_clr),
        .busy(b_busy), .clear_done(b_done), .err_wr(b_ewr), .err_addr(b_eaddr)
    );

    // Reference model of instance A: expected read results are queued at the sampling edge.
    typedef struct {int port; logic [DW-1:0] data; int cyc;} exp_t;
    exp_t          sbq[$];
    exp_t          m_e;
    logic [DW-1:0] mdl [D];
    logic [1:0]    mst;
    logic [AW-1:0] mcnt, m_a;
    logic [DW-1:0] m_d;
    logic          m_fire, m_cw;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) mdl[i] = '0;
            mst = 2'd0;
            mcnt = '0;
            sbq.delete();
        end else begin
            cyc++;
            m_fire = we && !mode && mst == 2'd0 && !clr;
            m_cw   = (mst == 2'd1);
            for (int p = 0; p < NR; p++) begin
                if (ren[p]) begin
                    m_a = raddr[p*AW +: AW];
                    m_d = mdl[m_a];
                    if (m_fire && wa == m_a) m_d = wd;
                    if (m_cw && mcnt == m_a) m_d = '0;
                    sbq.push_back('{p, m_d, cyc + 1});
                end
            end
            if (m_fire) mdl[wa] = wd;
            if (m_cw) mdl[mcnt] = '0;
            case (mst)
                2'd0: if (clr) begin mst = 2'd1; mcnt = '0; end
                2'd1: if (mcnt == AW'(D-1)) mst = 2'd2; else mcnt = mcnt + 1'b1;
                default: mst = 2'd0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int p = 0; p < NR; p++) begin
                if (rvld[p] === 1'b1) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL sb_spurious port %0d got %h cyc %0d", p, rdata[p*DW +: DW], cyc);
                    end else begin
                        m_e = sbq.pop_front();
                        if (m_e.port != p || m_e.data !== rdata[p*DW +: DW] || m_e.cyc != cyc) begin
                            errors++;
                            $display("FAIL sb_read port %0d got %h cyc %0d exp port %0d data %h cyc %0d",
                                     p, rdata[p*DW +: DW], cyc, m_e.port, m_e.data, m_e.cyc);
                        end
                    end
                end
            end
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                m_e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL sb_missing port %0d exp %h at cyc %0d now %0d", m_e.port, m_e.data, m_e.cyc, cyc);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d exp 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rvld !== '0 || rdata !== '0) begin
            errors++; $display("FAIL reset_rd got vld %b data %h exp 0", rvld, rdata);
        end
        checks++;
        if ({busy, cdone, ewr, eaddr} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {busy, cdone, ewr, eaddr});
        end
        checks++;
        if ({b_rvld, b_busy, b_done, b_ewr, b_eaddr} !== 5'b0 || b_rdata !== '0) begin
            errors++; $display("FAIL reset_b got %b %h exp 0", {b_rvld, b_busy, b_done, b_ewr, b_eaddr}, b_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int a = 0; a < D; a++) begin
            ren = 3'b001;
            raddr = '0;
            raddr[AW-1:0] = a[AW-1:0];
            @(negedge clk);
        end
        ren = '0;
        drain();
    endtask

    task automatic test_multi_read();
        logic [AW-1:0] addrs [3] = '{5'd22, 5'd28, 5'd31};
        logic [DW-1:0] words [3] = '{32'h4136_0000, 32'h40B2_041B, 32'h4187_8107};
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; wa = addrs[i]; wd = words[i];
            @(negedge clk);
        end
        we = 1'b0;
        checks++;
        if (ewr !== 1'b0) begin errors++; $display("FAIL multi_err_wr got %b exp 0", ewr); end
        mode = 1'b1;
        ren = 3'b111;
        raddr = {addrs[2], addrs[1], addrs[0]};
        @(negedge clk);
        ren = '0;
        @(negedge clk);
        checks++;
        if (rvld !== 3'b111 || rdata !== {words[2], words[1], words[0]}) begin
            errors++; $display("FAIL multi_read got %b %h exp 111 %h", rvld, rdata, {words[2], words[1], words[0]});
        end
        drain();
    endtask

    task automatic test_write_lock();
        mode = 1'b1; we = 1'b1; wa = 5'd22; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 1'b0;
        checks++;
        if (ewr !== 1'b1) begin errors++; $display("FAIL lock_err_wr got %b exp 1", ewr); end
        @(negedge clk);
        checks++;
        if (ewr !== 1'b0) begin errors++; $display("FAIL lock_err_wr_pulse got %b exp 0", ewr); end
        ren = 3'b001; raddr = '0; raddr[AW-1:0] = 5'd22;
        @(negedge clk);
        ren = '0;
        @(negedge clk);
        checks++;
        if (rdata[DW-1:0] !== 32'h4136_0000) begin
            errors++; $display("FAIL lock_readback got %h exp 41360000", rdata[DW-1:0]);
        end
        drain();
        mode = 1'b0;
    endtask

    task automatic test_bypass();
        mode = 1'b0; we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
        ren = 3'b011; raddr = {5'd0, 5'd5, 5'd5};
        b_we = 1'b1; b_wa = 5'd5; b_wd = 32'h1234_5678; b_ren = 1'b1; b_raddr = 5'd5;
        @(negedge clk);
        we = 1'b0; ren = '0; b_we = 1'b0; b_ren = 1'b0;
        @(negedge clk);
        checks++;
        if (rdata[2*DW-1:0] !== {2{32'h1234_5678}}) begin
            errors++; $display("FAIL bypass_fwd got %h exp 1234567812345678", rdata[2*DW-1:0]);
        end
        checks++;
        if (b_rvld !== 1'b1 || b_rdata !== 32'h0) begin
            errors++; $display("FAIL nobypass_old got %b %h exp 1 00000000", b_rvld, b_rdata);
        end
        @(negedge clk);
        checks++;
        if (b_rvld !== 1'b0 || b_rdata !== 32'h0) begin
            errors++; $display("FAIL rd_hold got %b %h exp 0 00000000", b_rvld, b_rdata);
        end
        b_ren = 1'b1;
        @(negedge clk);
        b_ren = 1'b0;
        @(negedge clk);
        checks++;
        if (b_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL nobypass_new got %h exp 12345678", b_rdata);
        end
        drain();
    endtask

    task automatic test_addr_range();
        b_ren = 1'b1; b_raddr = 5'd30;
        @(negedge clk);
        b_ren = 1'b0;
        checks++;
        if (b_eaddr !== 1'b1) begin errors++; $display("FAIL range_rd_err got %b exp 1", b_eaddr); end
        @(negedge clk);
        checks++;
        if (b_rvld !== 1'b1 || b_rdata !== 32'h0 || b_eaddr !== 1'b0) begin
            errors++; $display("FAIL range_rd got %b %h err %b exp 1 00000000 0", b_rvld, b_rdata, b_eaddr);
        end
        b_we = 1'b1; b_wa = 5'd25; b_wd = 32'hFFFF_FFFF;
        @(negedge clk);
        b_we = 1'b0;
        checks++;
        if (b_eaddr !== 1'b1 || b_ewr !== 1'b0) begin
            errors++; $display("FAIL range_wr got err_addr %b err_wr %b exp 1 0", b_eaddr, b_ewr);
        end
        b_ren = 1'b1; b_raddr = 5'd5;
        @(negedge clk);
        b_ren = 1'b0;
        @(negedge clk);
        checks++;
        if (b_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL range_nochange got %h exp 12345678", b_rdata);
        end
        checks++;
        if (eaddr !== 1'b0) begin errors++; $display("FAIL a_err_addr got %b exp 0", eaddr); end
    endtask

    task automatic test_clear();
        int n = 0;
        mode = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hFFFF_0000; clr = 1'b1;
        @(negedge clk);
        we = 1'b0; clr = 1'b0;
        checks++;
        if (ewr !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL clear_start got err_wr %b busy %b exp 1 1", ewr, busy);
        end
        while (busy === 1'b1 && n < 100) begin
            ren[1] = (n < 10) || (n >= 20 && n < 30);
            raddr[2*AW-1:AW] = (n < 10) ? 5'd28 : 5'd0;
            clr = (n == 5);
            @(negedge clk);
            n++;
        end
        ren = '0; clr = 1'b0;
        checks++;
        if (n != D || cdone !== 1'b1) begin
            errors++; $display("FAIL clear_len got %0d cycles done %b exp %0d 1", n, cdone, D);
        end
        @(negedge clk);
        checks++;
        if (cdone !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL clear_done_pulse got done %b busy %b exp 0 0", cdone, busy);
        end
        for (int a = 0; a < D; a++) begin
            ren = 3'b111;
            raddr = {3{a[AW-1:0]}};
            @(negedge clk);
        end
        ren = '0;
        drain();

        n = 0;
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        while (b_busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != BD || b_done !== 1'b1) begin
            errors++; $display("FAIL b_clear_len got %0d cycles done %b exp %0d 1", n, b_done, BD);
        end
        b_ren = 1'b1; b_raddr = 5'd19;
        @(negedge clk);
        b_ren = 1'b0;
        @(negedge clk);
        checks++;
        if (b_rdata !== BCV) begin errors++; $display("FAIL b_clear_value got %h exp %h", b_rdata, BCV); end
    endtask

    task automatic test_reset_mid_sweep();
        we = 1'b1; wa = 5'd30; wd = 32'hCAFE_F00D;
        @(negedge clk);
        wa = 5'd2; wd = 32'h1111_1111;
        @(negedge clk);
        we = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cdone !== 1'b0) begin
            errors++; $display("FAIL midreset_busy got busy %b done %b exp 0 0", busy, cdone);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
        @(negedge clk);
        we = 1'b0;
        checks++;
        if (ewr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_idle got err_wr %b busy %b exp 0 0", ewr, busy);
        end
        ren = 3'b111; raddr = {5'd7, 5'd2, 5'd30};
        @(negedge clk);
        ren = '0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        we = 1'b0; mode = 1'b0; clr = 1'b0; wa = '0; wd = '0; ren = '0; raddr = '0;
        b_we = 1'b0; b_mode = 1'b0; b_clr = 1'b0; b_ren = 1'b0; b_wa = '0; b_wd = '0; b_raddr = '0;
        test_reset();
        test_multi_read();
        test_write_lock();
        test_bypass();
        test_addr_range();
        test_clear();
        test_reset_mid_sweep();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
